vga_sync_gen: RTL

VGA raster timing generator for the 640x480 @ 60 Hz display path, sitting directly downstream of the pixel-enable divider. On each clock where `pixel_en` is high it advances horizontal and vertical counters, producing the sync pulses, the active-video flag and the current pixel coordinates for the colour/drawing logic. All outputs are registered and change only on enabled clock edges, except `frame_start`, which is a single-clock strobe.

---
 rtl/vga_sync_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// VGA 640x480 raster timing generator: pixel counters, active-low syncs and active-video flag.
// Define VGA_FRAME_START_EN to build the frame_start wrap strobe; otherwise frame_start is tied low.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] x_r;
  logic [9:0] y_r;
  logic [9:0] x_next_s;
  logic [9:0] y_next_s;
  logic       hsync_r;
  logic       vsync_r;
  logic       video_on_r;
  logic       hsync_next_s;
  logic       vsync_next_s;
  logic       video_on_next_s;

  // Next raster position: advance on pixel_en, wrap line then frame.
  always_comb begin
    x_next_s = x_r;
    y_next_s = y_r;
    if (pixel_en) begin
      if (x_r == H_LAST) begin
        x_next_s = 10'd0;
        if (y_r == V_LAST) begin
          y_next_s = 10'd0;
        end else begin
          y_next_s = y_r + 10'd1;
        end
      end else begin
        x_next_s = x_r + 10'd1;
        y_next_s = y_r;
      end
    end else begin
      x_next_s = x_r;
      y_next_s = y_r;
    end
  end

  // Decode from the next position so registered flags line up with the registered counts.
  always_comb begin
    hsync_next_s    = ~((x_next_s >= HS_FIRST) && (x_next_s <= HS_LAST));
    vsync_next_s    = ~((y_next_s >= VS_FIRST) && (y_next_s <= VS_LAST));
    video_on_next_s = (x_next_s < H_VIS) && (y_next_s < V_VIS);
  end

  // Counter and decode registers; reset state is the decode of position (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r        <= 10'd0;
      y_r        <= 10'd0;
      hsync_r    <= 1'b1;
      vsync_r    <= 1'b1;
      video_on_r <= 1'b1;
    end else begin
      x_r        <= x_next_s;
      y_r        <= y_next_s;
      hsync_r    <= hsync_next_s;
      vsync_r    <= vsync_next_s;
      video_on_r <= video_on_next_s;
    end
  end

  assign pixel_x  = x_r;
  assign pixel_y  = y_r;
  assign hsync    = hsync_r;
  assign vsync    = vsync_r;
  assign video_on = video_on_r;

`ifdef VGA_FRAME_START_EN
  logic wrap_s;
  logic frame_start_r;

  // Frame wrap: the enabled edge leaving the last pixel of the last line.
  always_comb begin
    wrap_s = 1'b0;
    if (pixel_en && (x_r == H_LAST) && (y_r == V_LAST)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // One-clk strobe; cleared on every other edge, including non-enabled ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= wrap_s;
    end
  end

  assign frame_start = frame_start_r;
`else
  assign frame_start = 1'b0;
`endif

endmodule
